// File: rtl/div_ctrl_if.sv
// Bundle of request, response and divider-IP signals between the execute
// stage and the division sequencing controller.
interface div_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [4:0]      req_tag;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_tag;
  logic            ip_valid;
  logic [XLEN-1:0] ip_dividend;
  logic [XLEN-1:0] ip_divisor;
  logic [XLEN-1:0] ip_quotient;
  logic [XLEN-1:0] ip_remainder;

  // master: pipeline plus divider IP; slave: the controller
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, flush,
           ip_quotient, ip_remainder,
    input  busy, resp_valid, resp_data, resp_tag,
           ip_valid, ip_dividend, ip_divisor
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, flush,
           ip_quotient, ip_remainder,
    output busy, resp_valid, resp_data, resp_tag,
           ip_valid, ip_dividend, ip_divisor
  );
endinterface

// File: rtl/div_ctrl.sv
// RV32M divide/remainder sequencer around a fixed-latency unsigned divider:
// special-case handling, magnitude conversion, latency count, sign fix-up.
module div_ctrl #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 10
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            rem_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic [4:0]      tag_q;
  logic [4:0]      rtag_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] res_q;

  logic            accept;
  logic            is_signed;
  logic            is_rem;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            cnt_zero;
  logic [XLEN-1:0] ip_res;
  logic [XLEN-1:0] final_res;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  // Operand decode and special-case result, evaluated on the request bus
  always_comb begin
    is_signed   = ~bus.req_op[0];
    is_rem      = bus.req_op[1];
    accept      = (state == IDLE) && bus.req_valid && !bus.flush;
    special     = 1'b0;
    special_res = '0;
    if (bus.req_b == '0) begin
      special     = 1'b1;
      special_res = is_rem ? bus.req_a : ALL_ONES;
    end else if (is_signed && bus.req_a == INT_MIN && bus.req_b == ALL_ONES) begin
      special     = 1'b1;
      special_res = is_rem ? '0 : bus.req_a;
    end
    mag_a = (is_signed && bus.req_a[XLEN-1]) ? neg2c(bus.req_a) : bus.req_a;
    mag_b = (is_signed && bus.req_b[XLEN-1]) ? neg2c(bus.req_b) : bus.req_b;
  end

  // IP result selection and sign correction
  always_comb begin
    cnt_zero  = (cnt == '0);
    ip_res    = rem_q ? bus.ip_remainder : bus.ip_quotient;
    final_res = ip_res;
    if (rem_q ? neg_r_q : neg_q_q)
      final_res = neg2c(ip_res);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush && state != IDLE)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      tag_q   <= '0;
      rtag_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem_q   <= is_rem;
        neg_q_q <= is_signed && (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]);
        neg_r_q <= is_signed && bus.req_a[XLEN-1];
        tag_q   <= bus.req_tag;
        if (special) begin
          res_q  <= special_res;
          rtag_q <= bus.req_tag;
        end else begin
          dvd_q <= mag_a;
          dvs_q <= mag_b;
        end
      end
      // ISSUE -> WAIT: counter reaches zero in the cycle the IP result is valid
      if (state == ISSUE)
        cnt <= CW'(LATENCY - 1);
      else if (state == WAIT && !cnt_zero)
        cnt <= cnt - CW'(1);
      // WAIT -> DONE: capture and sign-correct the IP output
      if (state == WAIT && cnt_zero && !bus.flush) begin
        res_q  <= final_res;
        rtag_q <= tag_q;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.resp_valid  = (state == DONE) && !bus.flush;
  assign bus.resp_data   = res_q;
  assign bus.resp_tag    = rtag_q;
  assign bus.ip_valid    = (state == ISSUE);
  assign bus.ip_dividend = dvd_q;
  assign bus.ip_divisor  = dvs_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: RV32M reference model, cycle-accurate timing
// expectations and a latency-exact divider IP stand-in.
module tb_div_ctrl;
  localparam int LAT = 10;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if #(.XLEN(32)) bus ();

  div_ctrl #(.XLEN(32), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Divider IP stand-in: output is correct only exactly LAT cycles after ip_valid
  int          ip_age = 0;
  logic [31:0] ip_dvd_s = '0;
  logic [31:0] ip_dvs_s = '0;
  always @(posedge clk) begin
    if (bus.ip_valid) begin
      ip_age   <= 1;
      ip_dvd_s <= bus.ip_dividend;
      ip_dvs_s <= bus.ip_divisor;
    end else if (ip_age > 0 && ip_age < LAT) begin
      ip_age <= ip_age + 1;
    end else begin
      ip_age <= 0;
    end
  end
  assign bus.ip_quotient  = (ip_age == LAT && ip_dvs_s != 0) ? ip_dvd_s / ip_dvs_s : 32'hDEAD_BEEF;
  assign bus.ip_remainder = (ip_age == LAT && ip_dvs_s != 0) ? ip_dvd_s % ip_dvs_s : 32'hBAD0_BAD0;

  // RV32M architectural result
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == INT_MIN && b == 32'hFFFF_FFFF) return a;
               else return $unsigned(sa / sb);
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  if (b == 0) return a;
               else if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
               else return $unsigned(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected behaviour, expressed as cycle windows
  int          m_bf = -1, m_bt = -2, m_rc = -1, m_ic = -1, m_wt = -2;
  logic [31:0] m_data = '0, m_lit = '0, m_idvd = '0, m_idvs = '0;
  logic [4:0]  m_tag = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        chk("busy",     32'(bus.busy),       32'(cyc >= m_bf && cyc <= m_bt));
        chk("resp_vld", 32'(bus.resp_valid), 32'(cyc == m_rc));
        chk("ip_vld",   32'(bus.ip_valid),   32'(cyc == m_ic));
        if (cyc == m_rc) begin
          chk("resp_data",     bus.resp_data,      m_data);
          chk("resp_data_lit", bus.resp_data,      m_lit);
          chk("resp_tag",      32'(bus.resp_tag),  32'(m_tag));
        end
        if (m_ic >= 0 && cyc >= m_ic && cyc <= m_wt) begin
          chk("ip_dividend", bus.ip_dividend, m_idvd);
          chk("ip_divisor",  bus.ip_divisor,  m_idvs);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a request in the current (IDLE) cycle; lit is the hand-computed result
  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic [31:0] lit);
    int  acc;
    logic sgn;
    logic spc;
    acc = cyc;
    sgn = (op == OP_DIV || op == OP_REM);
    spc = (b == 0) || (sgn && a == INT_MIN && b == 32'hFFFF_FFFF);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    m_data = ref_res(op, a, b);
    m_lit  = lit;
    m_tag  = tag;
    m_bf   = acc + 1;
    if (spc) begin
      m_rc = acc + 1;
      m_ic = -1;
      m_wt = -2;
    end else begin
      m_ic   = acc + 1;
      m_wt   = acc + 1 + LAT;
      m_rc   = acc + 2 + LAT;
      m_idvd = (sgn && a[31]) ? 32'(0) - a : a;
      m_idvs = (sgn && b[31]) ? 32'(0) - b : b;
    end
    m_bt = m_rc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    m_bt = cyc;
    if (m_rc >= cyc) m_rc = -1;
    if (m_wt > cyc) m_wt = cyc;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.flush     = 1'b0;

    // Pin the reference model with hand-computed values
    chk("model_divu",    ref_res(OP_DIVU, 32'd100, 32'd7), 32'd14);
    chk("model_rem_neg", ref_res(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_div_neg", ref_res(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_div0",    ref_res(OP_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("model_remu0",   ref_res(OP_REMU, 32'd5, 32'd0), 32'd5);
    chk("model_ovf_div", ref_res(OP_DIV, INT_MIN, 32'hFFFF_FFFF), INT_MIN);
    chk("model_ovf_rem", ref_res(OP_REM, INT_MIN, 32'hFFFF_FFFF), 32'd0);

    idle(3);
    rst = 1'b0;
    #1;
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_resp_vld", 32'(bus.resp_valid), 32'd0);
    chk("rst_ip_vld",   32'(bus.ip_valid),   32'd0);
    chk("rst_data",     bus.resp_data,       32'd0);
    chk("rst_tag",      32'(bus.resp_tag),   32'd0);
    chk("rst_dvd",      bus.ip_dividend,     32'd0);
    chk("rst_dvs",      bus.ip_divisor,      32'd0);
    chk_en = 1'b1;
    idle(1);

    // Normal path, back-to-back in the cycle after resp_valid
    req(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);             idle(12);
    req(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF); idle(12);
    req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD); idle(12);
    req(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFF2); idle(12);
    req(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFFE); idle(12);
    req(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFF2); idle(12);
    req(OP_DIV, INT_MIN, 32'd1, 5'd17, INT_MIN);            idle(12);
    req(OP_REMU, 32'd100, 32'd7, 5'd18, 32'd2);             idle(12);
    req(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd19, 32'hFFFF_FFFF); idle(12);

    // Special cases complete in one cycle
    req(OP_DIV, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);         idle(1);
    req(OP_REMU, 32'd5, 32'd0, 5'd9, 32'd5);                idle(1);
    req(OP_DIV, INT_MIN, 32'hFFFF_FFFF, 5'd10, INT_MIN);    idle(1);
    req(OP_REM, INT_MIN, 32'hFFFF_FFFF, 5'd11, 32'd0);      idle(3);

    // Flush mid-WAIT, then a new request the next cycle
    req(OP_DIVU, 32'd100, 32'd7, 5'd12, 32'd14);
    idle(4);
    do_flush();
    req(OP_DIVU, 32'd9, 32'd3, 5'd13, 32'd3);               idle(14);

    // Flush in IDLE blocks acceptance
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIVU;
    bus.req_a     = 32'd40;
    bus.req_b     = 32'd4;
    bus.flush     = 1'b1;
    idle(1);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    idle(3);

    // Flush in DONE suppresses the strobe
    req(OP_DIVU, 32'd50, 32'd5, 5'd20, 32'd10);
    idle(11);
    do_flush();
    idle(2);

    // Synchronous reset mid-operation
    req(OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd14);
    idle(3);
    rst  = 1'b1;
    m_bt = cyc;
    m_rc = -1;
    m_wt = cyc;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", bus.resp_data,     32'd0);
    chk("mid_rst_tag",  32'(bus.resp_tag), 32'd0);
    chk("mid_rst_dvd",  bus.ip_dividend,   32'd0);
    chk("mid_rst_dvs",  bus.ip_divisor,    32'd0);
    req(OP_DIVU, 32'd81, 32'd9, 5'd22, 32'd9);              idle(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
